// File: rtl/irda_fir_tx.sv
// FIR (4 Mb/s, 4PPM) frame transmitter: preamble, start flag, 4PPM data, CRC32, stop flag.
// Optional serial-interaction pulse after the stop flag when IRDA_FIR_TX_SIP_EN is defined.
module irda_fir_tx #(
   parameter int PA_COUNT = 16
) (
   input  logic        clk,
   input  logic        wb_rst_n,
   input  logic        fir_tx8_enable,
   input  logic        fir_tx_start,
   input  logic [15:0] fir_tx_len,
   input  logic [31:0] txfifo_dat_o,
   input  logic        txfifo_empty,
   output logic        txfifo_remove,
   output logic        tx_o,
   output logic        fir_tx_busy,
   output logic        fir_tx_done,
   output logic        fir_tx_underrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_PA, S_STA, S_DATA, S_CRC, S_STO, S_SIP, S_FIN
   } state_t;

   localparam logic [15:0] PA_PAT   = 16'b1000_0000_1010_1000;
   localparam logic [31:0] STA_PAT  = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
   localparam logic [31:0] STO_PAT  = 32'b0000_1100_0000_1100_0000_0110_0000_0110;
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [8:0]  PA_LAST  = 9'(PA_COUNT * 16 - 1);

   state_t      state;
   logic [8:0]  chip_cnt;
   logic [15:0] bytes_left;
   logic [1:0]  byte_in_word;
   logic        need_word;
   logic [31:0] word_reg;
   logic [1:0]  sym_reg;
   logic [31:0] crc;

   logic [31:0] sym_src;
   logic [1:0]  cur_bits;
   logic        sym_chip;
   logic [31:0] crc_next;

   // Two data bits per symbol, b0 first, folded into the reflected CRC.
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [1:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ CRC_POLY;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // The first symbol of a word is taken straight from the show-ahead FIFO head.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      sym_src = word_reg;
      if (state == S_DATA && need_word) sym_src = txfifo_dat_o;
      cur_bits = sym_src[1:0];
      if (chip_cnt[1:0] == 2'd0) sym_chip = (cur_bits == 2'd0);
      else                       sym_chip = (sym_reg == chip_cnt[1:0]);
      crc_next = crc_upd(crc, cur_bits);
   end

   assign txfifo_remove = fir_tx8_enable && (state == S_DATA) && need_word && !txfifo_empty;

   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state           <= S_IDLE;
         chip_cnt        <= '0;
         bytes_left      <= '0;
         byte_in_word    <= '0;
         need_word       <= 1'b0;
         word_reg        <= '0;
         sym_reg         <= '0;
         crc             <= 32'hFFFFFFFF;
         tx_o            <= 1'b0;
         fir_tx_busy     <= 1'b0;
         fir_tx_done     <= 1'b0;
         fir_tx_underrun <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every branch reads pre-edge register values.
         fir_tx_done     <= 1'b0;
         fir_tx_underrun <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fir_tx8_enable) tx_o <= 1'b0;
               if (fir_tx_start) begin
                  bytes_left  <= fir_tx_len;
                  fir_tx_busy <= 1'b1;
                  crc         <= 32'hFFFFFFFF;
                  chip_cnt    <= '0;
                  state       <= S_PA;
               end
            end
            S_PA: if (fir_tx8_enable) begin
               tx_o <= PA_PAT[~chip_cnt[3:0]];
               if (chip_cnt == PA_LAST) begin
                  chip_cnt <= '0;
                  state    <= S_STA;
               end else chip_cnt <= chip_cnt + 9'd1;
            end
            S_STA: if (fir_tx8_enable) begin
               tx_o <= STA_PAT[~chip_cnt[4:0]];
               if (chip_cnt == 9'd31) begin
                  chip_cnt     <= '0;
                  byte_in_word <= '0;
                  if (bytes_left == 16'd0) begin
                     word_reg <= ~crc;
                     state    <= S_CRC;
                  end else begin
                     need_word <= 1'b1;
                     state     <= S_DATA;
                  end
               end else chip_cnt <= chip_cnt + 9'd1;
            end
            S_DATA: if (fir_tx8_enable) begin
               if (need_word && txfifo_empty) begin
                  tx_o            <= 1'b0;
                  fir_tx_busy     <= 1'b0;
                  fir_tx_underrun <= 1'b1;
                  need_word       <= 1'b0;
                  chip_cnt        <= '0;
                  state           <= S_IDLE;
               end else begin
                  tx_o <= sym_chip;
                  if (chip_cnt[1:0] == 2'd0) begin
                     sym_reg   <= cur_bits;
                     word_reg  <= sym_src >> 2;
                     crc       <= crc_next;
                     need_word <= 1'b0;
                  end
                  // 16 chips per byte; the CRC register is final once the last byte ends.
                  if (chip_cnt[3:0] == 4'd15) begin
                     chip_cnt     <= '0;
                     bytes_left   <= bytes_left - 16'd1;
                     byte_in_word <= byte_in_word + 2'd1;
                     if (byte_in_word == 2'd3) need_word <= 1'b1;
                     if (bytes_left == 16'd1) begin
                        word_reg  <= ~crc;
                        need_word <= 1'b0;
                        state     <= S_CRC;
                     end
                  end else chip_cnt <= chip_cnt + 9'd1;
               end
            end
            S_CRC: if (fir_tx8_enable) begin
               tx_o <= sym_chip;
               if (chip_cnt[1:0] == 2'd0) begin
                  sym_reg  <= cur_bits;
                  word_reg <= sym_src >> 2;
               end
               if (chip_cnt == 9'd63) begin
                  chip_cnt <= '0;
                  state    <= S_STO;
               end else chip_cnt <= chip_cnt + 9'd1;
            end
            S_STO: if (fir_tx8_enable) begin
               tx_o <= STO_PAT[~chip_cnt[4:0]];
               if (chip_cnt == 9'd31) begin
                  chip_cnt <= '0;
`ifdef IRDA_FIR_TX_SIP_EN
                  state    <= S_SIP;
`else
                  state    <= S_FIN;
`endif
               end else chip_cnt <= chip_cnt + 9'd1;
            end
`ifdef IRDA_FIR_TX_SIP_EN
            S_SIP: if (fir_tx8_enable) begin
               tx_o <= (chip_cnt < 9'd13);
               if (chip_cnt == 9'd69) begin
                  chip_cnt <= '0;
                  state    <= S_FIN;
               end else chip_cnt <= chip_cnt + 9'd1;
            end
`endif
            // Completion is reported one clk after the last chip leaves.
            S_FIN: begin
               fir_tx_busy <= 1'b0;
               fir_tx_done <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irda_fir_tx.sv
// Scoreboard bench for irda_fir_tx: a frame-level model queues expected chips,
// a monitor pops and compares every chip the DUT emits while busy.
module tb_irda_fir_tx;

   localparam int PA = 16;

   logic        clk = 1'b0;
   logic        wb_rst_n;
   logic        strobe;
   logic        start;
   logic [15:0] len_in;
   logic [31:0] dat;
   logic        empty;
   logic        txfifo_remove, tx_o, busy, done, underrun;

   irda_fir_tx #(.PA_COUNT(PA)) dut (
      .clk(clk), .wb_rst_n(wb_rst_n), .fir_tx8_enable(strobe), .fir_tx_start(start),
      .fir_tx_len(len_in), .txfifo_dat_o(dat), .txfifo_empty(empty),
      .txfifo_remove(txfifo_remove), .tx_o(tx_o), .fir_tx_busy(busy),
      .fir_tx_done(done), .fir_tx_underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit          exp_chips[$];
   logic [31:0] fifo_q[$];
   logic [31:0] frame_words[$];
   int stb_div = 2;
   int stb_cnt = 0;
   bit pop_pend = 1'b0;
   int pop_cnt = 0, done_cnt = 0, unr_cnt = 0, chip_no = 0;
   logic busy_neg = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // FIFO model and chip strobe generator; inputs change on the falling edge.
   always @(negedge clk) begin
      logic [31:0] junk;
      if (pop_pend) begin
         if (fifo_q.size() > 0) junk = fifo_q.pop_front();
         pop_pend = 1'b0;
      end
      empty    = (fifo_q.size() == 0);
      dat      = empty ? 32'h0 : fifo_q[0];
      strobe   = (stb_cnt == 0);
      stb_cnt  = (stb_cnt + 1 >= stb_div) ? 0 : stb_cnt + 1;
      busy_neg = busy;
      #1;
      if (txfifo_remove) begin
         pop_pend = 1'b1;
         pop_cnt++;
      end
   end

   // Monitor: every strobe edge during which the frame stays busy carries one chip.
   always @(posedge clk) begin
      bit stb_s, bprev, e;
      stb_s = strobe;
      bprev = busy_neg;
      #1;
      if (underrun) unr_cnt++;
      if (done) begin
         done_cnt++;
         check("done_with_busy_low", busy, 0);
      end
      if (stb_s && bprev && busy) begin
         check("extra_chip", exp_chips.size() > 0, 1);
         if (exp_chips.size() > 0) begin
            e = exp_chips.pop_front();
            check($sformatf("chip%0d", chip_no), tx_o, e);
         end
         chip_no++;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] byte_at(int k);
      logic [31:0] w;
      w = frame_words[k / 4];
      return w[8 * (k % 4) +: 8];
   endfunction

   function automatic logic [31:0] crc32_ref(int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < n; k++) begin
         c = c ^ {24'h0, byte_at(k)};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic push_bits(logic [31:0] pat, int n);
      for (int i = n - 1; i >= 0; i--) exp_chips.push_back(pat[i]);
   endtask

   task automatic push_byte(logic [7:0] b);
      for (int s = 0; s < 4; s++) begin
         int v;
         v = (b >> (2 * s)) & 3;
         for (int c = 0; c < 4; c++) exp_chips.push_back(c == v);
      end
   endtask

   task automatic build_expected(int len, output int exp_pops, output int exp_under);
      int avail;
      logic [31:0] crc;
      avail = 4 * frame_words.size();
      for (int i = 0; i < PA; i++) push_bits(32'h80A8, 16);
      push_bits(32'h0C0C6060, 32);
      if (len > avail) begin
         for (int k = 0; k < avail; k++) push_byte(byte_at(k));
         exp_pops  = frame_words.size();
         exp_under = 1;
      end else begin
         for (int k = 0; k < len; k++) push_byte(byte_at(k));
         crc = crc32_ref(len);
         for (int k = 0; k < 4; k++) push_byte(crc[8 * k +: 8]);
         push_bits(32'h0C0C0606, 32);
`ifdef IRDA_FIR_TX_SIP_EN
         for (int i = 0; i < 70; i++) exp_chips.push_back(i < 13);
`endif
         exp_pops  = (len + 3) / 4;
         exp_under = 0;
      end
   endtask

   task automatic run_frame(string tag, int len, int div, bit poke);
      int ep, eu, p0, d0, u0, t;
      stb_div = div;
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      build_expected(len, ep, eu);
      p0 = pop_cnt; d0 = done_cnt; u0 = unr_cnt;
      repeat (2) @(negedge clk);
      len_in = len[15:0];
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      if (poke) begin
         repeat (40) @(negedge clk);
         len_in = 16'd3;
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (busy && t < 40000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_timeout"}, t < 40000, 1);
      repeat (3) @(negedge clk);
      check({tag, "_chips_left"}, exp_chips.size(), 0);
      check({tag, "_pops"}, pop_cnt - p0, ep);
      check({tag, "_done"}, done_cnt - d0, eu ? 0 : 1);
      check({tag, "_underrun"}, unr_cnt - u0, eu);
      check({tag, "_tx_idle"}, tx_o, 0);
      exp_chips.delete();
      fifo_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ep, eu, len, nw, div;
      wb_rst_n = 1'b0;
      start    = 1'b0;
      len_in   = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_o", tx_o, 0);
      check("rst_busy", busy, 0);
      check("rst_remove", txfifo_remove, 0);
      check("rst_done", done, 0);
      check("rst_underrun", underrun, 0);
      wb_rst_n = 1'b1;

      frame_words = '{32'h00000000};
      check("model_crc_zero4", crc32_ref(4), 32'h2144DF1C);
      run_frame("len4", 4, 2, 1'b0);

      frame_words.delete();
      run_frame("len0", 0, 2, 1'b0);

      frame_words = '{32'h04030201, 32'h000000AA};
      run_frame("len5_poke", 5, 2, 1'b1);

      frame_words = '{32'h11223344};
      run_frame("under8", 8, 2, 1'b0);

      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 12);
         div = (f == 0) ? 1 : $urandom_range(1, 3);
         nw  = (len + 3) / 4;
         if ($urandom_range(0, 2) == 0) nw--;
         frame_words.delete();
         for (int i = 0; i < nw; i++) frame_words.push_back($urandom);
         run_frame($sformatf("rand%0d", f), len, div, $urandom_range(0, 1));
      end

      // Asynchronous reset in the middle of DATA.
      frame_words = '{32'h5A3C96F1, 32'h0F0FA5A5};
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      stb_div = 2;
      build_expected(8, ep, eu);
      @(negedge clk);
      len_in = 16'd8;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (700) @(negedge clk);
      check("rst_mid_busy_before", busy, 1);
      #3;
      wb_rst_n = 1'b0;
      #1;
      check("rst_mid_tx_o", tx_o, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_remove", txfifo_remove, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_underrun", underrun, 0);
      @(negedge clk);
      exp_chips.delete();
      fifo_q.delete();
      repeat (3) @(negedge clk);
      wb_rst_n = 1'b1;
      frame_words = '{32'h000000C3};
      run_frame("after_rst_len1", 1, 2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
